// File: rtl/sp_pkg.sv
// sp_pkg: shared state/axis encodings and default position limits for the solar tracker
package sp_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, SETTLE = 3'd1, REQ = 3'd2, EVAL = 3'd3, MOVE = 3'd4} state_t;
  typedef enum logic {AXIS_H = 1'b0, AXIS_V = 1'b1} axis_t;
  localparam int SP_POS_MIN = 0;
  localparam int SP_POS_MAX = 180;
  localparam int SP_POS_MID = (SP_POS_MIN + SP_POS_MAX) / 2;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: reloadable down-counter; done while the count sits at zero
module settle_timer #(
  parameter int CYC = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  output logic done
);
  localparam int W = $clog2(CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else cnt <= load ? W'(CYC) : cnt - W'(cnt != '0);
  assign done = cnt == '0;
endmodule

// File: rtl/track_step_scheduler.sv
// track_step_scheduler: two-axis hill-climbing servo scheduler with settle delay and ADC handshake
module track_step_scheduler import sp_pkg::*; #(
  parameter int POS_W      = 8,
  parameter int V_W        = 12,
  parameter int POS_MIN    = SP_POS_MIN,
  parameter int POS_MAX    = SP_POS_MAX,
  parameter int STEP       = 2,
  parameter int SETTLE_CYC = 1000,
  parameter int HYST       = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             man_l,
  input  logic             man_r,
  input  logic             man_u,
  input  logic             man_d,
  output logic             adc_req,
  input  logic             adc_ack,
  input  logic [V_W-1:0]   adc_data,
  output logic [POS_W-1:0] pos_h,
  output logic [POS_W-1:0] pos_v,
  output logic             axis,
  output logic             dir_h,
  output logic             dir_v,
  output logic [V_W-1:0]   v_best,
  output logic [2:0]       state,
  output logic             busy
);
  localparam logic [POS_W-1:0] MID = POS_W'((POS_MIN + POS_MAX) / 2);
  state_t st, st_next;
  axis_t ax;
  logic base, done, step_ok, better, cur_dir, swap;
  logic [1:0] fails, fails_inc;
  logic [V_W-1:0] sample;
  logic [POS_W-1:0] cur, prev_pos;
  int tgt;
  function automatic logic [POS_W-1:0] clamp(input int p);
    return POS_W'(p < POS_MIN ? POS_MIN : (p > POS_MAX ? POS_MAX : p));
  endfunction
  settle_timer #(.CYC(SETTLE_CYC)) u_timer (.CLK(CLK), .RST_N(RST_N), .load(st != SETTLE), .done(done));
  assign cur       = ax == AXIS_V ? pos_v : pos_h;
  assign cur_dir   = ax == AXIS_V ? dir_v : dir_h;
  assign better    = {1'b0, sample} > {1'b0, v_best} + (V_W+1)'(HYST);
  assign fails_inc = fails + 2'd1;
  assign swap      = fails_inc == 2'd2;
  assign state     = st;
  assign axis      = ax;
  always_comb begin
    tgt     = cur_dir ? int'(cur) + STEP : int'(cur) - STEP;
    step_ok = tgt >= POS_MIN && tgt <= POS_MAX;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) st <= IDLE;
    else st <= st_next;
  always_comb begin
    case (st)
      IDLE:    st_next = en ? SETTLE : IDLE;
      SETTLE:  st_next = done ? REQ : SETTLE;
      REQ:     st_next = adc_ack ? EVAL : REQ;
      EVAL:    st_next = MOVE;
      MOVE:    st_next = step_ok ? SETTLE : MOVE;
      default: st_next = IDLE;
    endcase
    if (!en) st_next = IDLE;
  end
  // Abort (en low) freezes everything; manual steps only act while idle and disabled
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pos_h    <= MID;
      pos_v    <= MID;
      prev_pos <= MID;
      ax       <= AXIS_H;
      dir_h    <= 1'b1;
      dir_v    <= 1'b1;
      v_best   <= '0;
      sample   <= '0;
      fails    <= '0;
      base     <= 1'b0;
      adc_req  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      adc_req <= st_next == REQ;
      busy    <= st_next != IDLE;
      if (!en) begin
        if (st == IDLE) begin
          pos_h <= clamp(int'(pos_h) + (man_r ? STEP : 0) - (man_l ? STEP : 0));
          pos_v <= clamp(int'(pos_v) + (man_u ? STEP : 0) - (man_d ? STEP : 0));
        end
      end else if (st == IDLE) base <= 1'b1;
      else if (st == REQ && adc_ack) sample <= adc_data;
      else if (st == EVAL && (base || better)) begin
        v_best <= sample;
        base   <= 1'b0;
        if (!base) fails <= '0;
      end else if (st == EVAL || (st == MOVE && !step_ok)) begin
        if (st == EVAL && ax == AXIS_V) pos_v <= prev_pos;
        if (st == EVAL && ax == AXIS_H) pos_h <= prev_pos;
        if (ax == AXIS_V) dir_v <= ~dir_v;
        else dir_h <= ~dir_h;
        fails <= swap ? 2'd0 : fails_inc;
        if (swap) ax <= ax == AXIS_H ? AXIS_V : AXIS_H;
      end else if (st == MOVE) begin
        prev_pos <= cur;
        if (ax == AXIS_V) pos_v <= POS_W'(tgt);
        else pos_h <= POS_W'(tgt);
      end
    end
endmodule

// File: tb/tb_track_step_scheduler.sv
// tb_track_step_scheduler: directed scenarios for the hill-climbing scheduler (SETTLE_CYC = 5)
module tb_track_step_scheduler;
  logic CLK = 0, RST_N = 0, en = 0;
  logic man_l = 0, man_r = 0, man_u = 0, man_d = 0;
  logic adc_ack = 0;
  logic [11:0] adc_data = '0;
  logic adc_req, axis, dir_h, dir_v, busy;
  logic [7:0] pos_h, pos_v;
  logic [11:0] v_best;
  logic [2:0] state;
  int checks = 0, errors = 0;

  track_step_scheduler #(.SETTLE_CYC(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en),
    .man_l(man_l), .man_r(man_r), .man_u(man_u), .man_d(man_d),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .pos_h(pos_h), .pos_v(pos_v), .axis(axis), .dir_h(dir_h), .dir_v(dir_v),
    .v_best(v_best), .state(state), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    en = 0; man_l = 0; man_r = 0; man_u = 0; man_d = 0; adc_ack = 0; adc_data = '0;
    RST_N = 0;
    tick; tick;
    RST_N = 1;
    tick;
  endtask

  task automatic pulse(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      man_l = k == 0; man_r = k == 1; man_u = k == 2; man_d = k == 3;
      tick;
    end
    man_l = 0; man_r = 0; man_u = 0; man_d = 0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (adc_req !== 1'b1 && n < 50) begin tick; n++; end
    checks++;
    if (adc_req !== 1'b1) begin errors++; $display("FAIL req_timeout got %0b want 1", adc_req); end
  endtask

  task automatic do_sample(input logic [11:0] d);
    wait_req;
    adc_ack = 1; adc_data = d;
    tick;
    adc_ack = 0;
  endtask

  task automatic test_reset;
    RST_N = 0; en = 0;
    tick; tick;
    checks++; if (pos_h !== 8'd90) begin errors++; $display("FAIL reset_pos_h got %0d want 90", pos_h); end
    checks++; if (pos_v !== 8'd90) begin errors++; $display("FAIL reset_pos_v got %0d want 90", pos_v); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (adc_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", adc_req); end
    checks++; if ({busy, axis, dir_h, dir_v} !== 4'b0011) begin errors++; $display("FAIL reset_flags got %b want 0011", {busy, axis, dir_h, dir_v}); end
    checks++; if (v_best !== 12'd0) begin errors++; $display("FAIL reset_vbest got %0d want 0", v_best); end
    RST_N = 1;
    tick;
  endtask

  task automatic test_manual;
    do_reset;
    pulse(1, 3);
    checks++; if (pos_h !== 8'd96) begin errors++; $display("FAIL man_r3 got %0d want 96", pos_h); end
    pulse(0, 1);
    checks++; if (pos_h !== 8'd94) begin errors++; $display("FAIL man_l got %0d want 94", pos_h); end
    pulse(3, 45);
    checks++; if (pos_v !== 8'd0) begin errors++; $display("FAIL man_d_to_min got %0d want 0", pos_v); end
    pulse(3, 1);
    checks++; if (pos_v !== 8'd0) begin errors++; $display("FAIL man_d_clamp got %0d want 0", pos_v); end
    pulse(2, 1);
    checks++; if (pos_v !== 8'd2) begin errors++; $display("FAIL man_u got %0d want 2", pos_v); end
  endtask

  task automatic test_improve;
    do_reset;
    en = 1;
    do_sample(12'd2000);
    tick;
    checks++; if (v_best !== 12'd2000) begin errors++; $display("FAIL base_vbest got %0d want 2000", v_best); end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL base_to_move got %0d want 4", state); end
    tick;
    checks++; if (pos_h !== 8'd92) begin errors++; $display("FAIL step1_pos got %0d want 92", pos_h); end
    do_sample(12'd2010);
    tick;
    checks++; if (v_best !== 12'd2010) begin errors++; $display("FAIL improve_vbest got %0d want 2010", v_best); end
    tick;
    checks++; if (pos_h !== 8'd94) begin errors++; $display("FAIL step2_pos got %0d want 94", pos_h); end
    checks++; if (dir_h !== 1'b1) begin errors++; $display("FAIL improve_dir got %0b want 1", dir_h); end
    en = 0;
    tick;
  endtask

  task automatic test_fail_swap;
    do_reset;
    en = 1;
    do_sample(12'd2000);
    tick; tick;
    do_sample(12'd2002);
    tick;
    checks++; if (pos_h !== 8'd90) begin errors++; $display("FAIL revert_pos got %0d want 90", pos_h); end
    checks++; if (dir_h !== 1'b0) begin errors++; $display("FAIL revert_dir got %0b want 0", dir_h); end
    checks++; if (v_best !== 12'd2000) begin errors++; $display("FAIL revert_vbest got %0d want 2000", v_best); end
    tick;
    checks++; if (pos_h !== 8'd88) begin errors++; $display("FAIL reverse_step got %0d want 88", pos_h); end
    do_sample(12'd2004);
    tick;
    checks++; if (axis !== 1'b1) begin errors++; $display("FAIL axis_swap got %0b want 1", axis); end
    checks++; if (pos_h !== 8'd90) begin errors++; $display("FAIL revert2_pos got %0d want 90", pos_h); end
    tick;
    checks++; if (pos_v !== 8'd92) begin errors++; $display("FAIL v_step got %0d want 92", pos_v); end
    en = 0;
    tick;
  endtask

  task automatic test_boundary;
    do_reset;
    pulse(1, 46);
    checks++; if (pos_h !== 8'd180) begin errors++; $display("FAIL man_r_clamp got %0d want 180", pos_h); end
    en = 1;
    do_sample(12'd2000);
    tick;
    tick;
    checks++; if (pos_h !== 8'd180) begin errors++; $display("FAIL bound_pos got %0d want 180", pos_h); end
    checks++; if (dir_h !== 1'b0) begin errors++; $display("FAIL bound_dir got %0b want 0", dir_h); end
    checks++; if (dut.fails !== 2'd1) begin errors++; $display("FAIL bound_fails got %0d want 1", dut.fails); end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL bound_retry got %0d want 4", state); end
    tick;
    checks++; if (pos_h !== 8'd178) begin errors++; $display("FAIL bound_retry_pos got %0d want 178", pos_h); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL bound_settle got %0d want 1", state); end
    en = 0;
    tick;
  endtask

  task automatic test_abort;
    do_reset;
    en = 1;
    do_sample(12'd2000);
    tick; tick;
    wait_req;
    adc_ack = 1; adc_data = 12'd4000; en = 0;
    tick;
    adc_ack = 0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d want 0", state); end
    checks++; if (adc_req !== 1'b0) begin errors++; $display("FAIL abort_req got %0b want 0", adc_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    tick;
    checks++; if (v_best !== 12'd2000) begin errors++; $display("FAIL abort_vbest got %0d want 2000", v_best); end
    checks++; if (pos_h !== 8'd92) begin errors++; $display("FAIL abort_pos got %0d want 92", pos_h); end
  endtask

  task automatic test_settle_timing;
    int n = 0;
    do_reset;
    en = 1;
    do_sample(12'd2000);
    tick; tick;
    checks++; if (pos_h !== 8'd92 || adc_req !== 1'b0) begin errors++; $display("FAIL timing_start got pos %0d req %0b want 92 0", pos_h, adc_req); end
    do begin tick; n++; end while (adc_req !== 1'b1 && n < 20);
    checks++; if (n !== 6) begin errors++; $display("FAIL settle_latency got %0d want 6", n); end
    en = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_manual;
    test_improve;
    test_fail_swap;
    test_boundary;
    test_abort;
    test_settle_timing;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
